// File: rtl/credit_pool_pkg.sv
// Shared width helpers and error codes for the credit pool arbiter and its sub-blocks.
package credit_pool_pkg;

  // Bits needed to hold any count in 0..n inclusive.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  typedef enum logic [1:0] {
    RET_ERR_NONE      = 2'd0,
    RET_ERR_UNDERFLOW = 2'd1
  } ret_err_code_e;

endpackage

// File: rtl/credit_pool_rr_arb.sv
// Round-robin arbiter: one-hot grant searching upward from a registered pointer,
// pointer moves to winner+1 when en is asserted.
module credit_pool_rr_arb #(
  parameter int p_n = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [p_n-1:0] req,
  input  logic           en,
  output logic [p_n-1:0] grant
);

  localparam int PW = (p_n > 1) ? $clog2(p_n) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] win;
  logic          found;

  always_comb begin
    int idx;
    grant = '0;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < p_n; k++) begin
      idx = (int'(ptr) + k) % p_n;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        win        = PW'(idx);
        found      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (en && found) begin
      ptr <= (int'(win) == p_n - 1) ? '0 : win + PW'(1);
    end
  end

endmodule

// File: rtl/credit_pool_arbiter.sv
// Shares a fixed credit pool among requesters: round-robin single grant per cycle,
// per-requester cap, single-cycle credit returns.
module credit_pool_arbiter
  import credit_pool_pkg::*;
#(
  parameter  int p_nreqs       = 4,
  parameter  int p_num_credits = 8,
  parameter  int p_max_per_req = 4,
  localparam int FW            = cnt_w(p_num_credits),
  localparam int HW            = cnt_w(p_max_per_req)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [p_nreqs-1:0]   req_val,
  output logic [p_nreqs-1:0]   req_rdy,
  input  logic [p_nreqs-1:0]   ret,
  output logic [FW-1:0]        free_count,
  output logic [p_nreqs*HW-1:0] held,
  output logic                 pool_empty,
  output logic                 pool_full,
  output logic                 ret_err
);

  logic [FW-1:0]      free_q;
  logic [FW-1:0]      free_next;
  logic [HW-1:0]      held_q [p_nreqs];
  logic [p_nreqs-1:0] elig;
  logic [p_nreqs-1:0] grant;
  logic [p_nreqs-1:0] vret;

  // Eligibility looks at registered state only; returns become grantable next cycle.
  always_comb begin
    elig = '0;
    for (int i = 0; i < p_nreqs; i++) begin
      elig[i] = !reset && req_val[i] && (held_q[i] < HW'(p_max_per_req)) && (free_q != '0);
    end
  end

  credit_pool_rr_arb #(
    .p_n (p_nreqs)
  ) u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (elig),
    .en    (|grant),
    .grant (grant)
  );

  assign req_rdy = grant;

  // A return is honoured only if the requester holds a credit or is granted one this cycle.
  always_comb begin
    vret = '0;
    for (int i = 0; i < p_nreqs; i++) begin
      vret[i] = ret[i] && ((held_q[i] != '0) || grant[i]);
    end
  end

  for (genvar i = 0; i < p_nreqs; i++) begin : g_held
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        held_q[i] <= '0;
      end else if (grant[i] && !vret[i]) begin
        held_q[i] <= held_q[i] + HW'(1);
      end else if (vret[i] && !grant[i]) begin
        held_q[i] <= held_q[i] - HW'(1);
      end
    end
    assign held[i*HW +: HW] = held_q[i];
  end

  always_comb begin
    free_next = free_q;
    if (|grant) begin
      free_next = free_next - FW'(1);
    end
    for (int i = 0; i < p_nreqs; i++) begin
      if (vret[i]) begin
        free_next = free_next + FW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      free_q  <= FW'(p_num_credits);
      ret_err <= 1'b0;
    end else begin
      free_q  <= free_next;
      ret_err <= |(ret & ~vret);
    end
  end

  assign free_count = free_q;
  assign pool_empty = (free_q == '0);
  assign pool_full  = (free_q == FW'(p_num_credits));

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(|(ret & ~vret)))
        else $warning("credit_pool_arbiter: credit returned by a requester holding none");
    end
  end
`endif

endmodule

// File: tb/tb_credit_pool_arbiter.sv
// Bench for credit_pool_arbiter: directed scenarios plus random traffic against a
// count-level model of the pool.
module tb_credit_pool_arbiter;

  localparam int N   = 4;
  localparam int NC  = 8;
  localparam int CAP = 4;
  localparam int FW  = 4;
  localparam int HW  = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_val;
  logic [N-1:0]    req_rdy;
  logic [N-1:0]    ret;
  logic [FW-1:0]   free_count;
  logic [N*HW-1:0] held;
  logic            pool_empty;
  logic            pool_full;
  logic            ret_err;

  int checks = 0;
  int errors = 0;

  int held_m [N];
  int free_m;
  int ptr_m;
  bit err_m;

  always #5 clk = ~clk;

  credit_pool_arbiter #(
    .p_nreqs       (N),
    .p_num_credits (NC),
    .p_max_per_req (CAP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_val    (req_val),
    .req_rdy    (req_rdy),
    .ret        (ret),
    .free_count (free_count),
    .held       (held),
    .pool_empty (pool_empty),
    .pool_full  (pool_full),
    .ret_err    (ret_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int dut_held(input int i);
    logic [N*HW-1:0] h;
    h = held;
    return int'(h[i*HW +: HW]);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N; i++) held_m[i] = 0;
    free_m = NC;
    ptr_m  = 0;
    err_m  = 1'b0;
  endfunction

  // First requester at or after the priority pointer that asks and may take a credit.
  function automatic int model_winner(input logic [N-1:0] v);
    int idx;
    for (int k = 0; k < N; k++) begin
      idx = (ptr_m + k) % N;
      if (v[idx] && held_m[idx] < CAP && free_m > 0) return idx;
    end
    return -1;
  endfunction

  task automatic check_state();
    int sum;
    sum = int'(free_count);
    chk("free_count", free_count, free_m);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("held%0d", i), dut_held(i), held_m[i]);
      sum += dut_held(i);
    end
    chk("pool_empty", pool_empty, free_m == 0);
    chk("pool_full", pool_full, free_m == NC);
    chk("ret_err", ret_err, err_m);
    chk("conservation", sum, NC);
  endtask

  // Called at a negedge; drives one cycle, checks grant, then checks registered state.
  task automatic cycle(input logic [N-1:0] v, input logic [N-1:0] r);
    int w;
    logic [N-1:0] exp_rdy;
    logic g, vr;
    req_val = v;
    ret     = r;
    #1;
    w = model_winner(v);
    exp_rdy = (w >= 0) ? N'(1 << w) : '0;
    chk("req_rdy", req_rdy, exp_rdy);
    @(posedge clk);
    err_m = 1'b0;
    for (int i = 0; i < N; i++) begin
      g  = (i == w);
      vr = r[i] && (held_m[i] > 0 || g);
      if (r[i] && !vr) err_m = 1'b1;
      held_m[i] += int'(g) - int'(vr);
      free_m    += int'(vr);
    end
    if (w >= 0) begin
      free_m -= 1;
      ptr_m = (w + 1) % N;
    end
    #1;
    check_state();
    @(negedge clk);
  endtask

  // Asserts reset between edges and checks that outputs clear before the next edge.
  task automatic do_reset();
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_state();
    chk("rdy_in_reset", req_rdy, 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [N-1:0] v, r;
    reset   = 1'b0;
    req_val = '0;
    ret     = '0;
    model_reset();
    @(negedge clk);

    req_val = '1;
    do_reset();

    repeat (3) cycle('0, '0);

    repeat (8) cycle(4'b1111, '0);
    chk("fill_free", free_count, 0);
    chk("fill_empty", pool_empty, 1);
    for (int i = 0; i < N; i++) chk("fill_held", dut_held(i), 2);

    cycle(4'b0001, 4'b0010);
    cycle(4'b0001, 4'b0000);
    chk("empty_then_grant_held0", dut_held(0), 3);

    do_reset();
    repeat (6) cycle(4'b0001, '0);
    chk("cap_held0", dut_held(0), CAP);
    chk("cap_free", free_count, 4);

    cycle('0, 4'b1000);
    chk("bad_ret_free", free_count, 4);
    chk("bad_ret_err", ret_err, 1);
    cycle('0, '0);
    chk("bad_ret_err_clear", ret_err, 0);

    cycle(4'b0100, '0);
    cycle(4'b0100, 4'b0100);
    chk("same_cycle_held2", dut_held(2), 1);
    chk("same_cycle_free", free_count, 3);

    do_reset();
    repeat (6) cycle(4'b1111, '0);
    chk("pre_reset_free", free_count, 2);
    req_val = 4'b1111;
    do_reset();
    cycle(4'b1111, '0);
    chk("post_reset_held0", dut_held(0), 1);

    for (int n = 0; n < 400; n++) begin
      v = N'($urandom_range(0, (1 << N) - 1));
      r = '0;
      for (int i = 0; i < N; i++) begin
        if (held_m[i] > 0 && $urandom_range(0, 2) == 0) r[i] = 1'b1;
      end
      if ($urandom_range(0, 31) == 0) r[$urandom_range(0, N - 1)] = 1'b1;
      cycle(v, r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
